// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester-side and memory-port signals of mem_bus_arbiter
interface mem_bus_arbiter_if #(parameter int ADDR_W = 32);
  logic              ic_rd_req, ic_rd_gnt, ic_rd_valid, ic_rd_last;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic [31:0]       ic_rd_data;
  logic              dc_rd_req, dc_rd_single, dc_rd_gnt, dc_rd_valid, dc_rd_last;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic [31:0]       dc_rd_data;
  logic              dc_wr_req, dc_wr_single, dc_wr_gnt, dc_wr_beat_ack, dc_wr_done;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [31:0]       dc_wr_data;
  logic [3:0]        dc_wr_strb;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid, mem_rlast;
  logic              mem_wvalid, mem_wlast, mem_wready, mem_bvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic [31:0]       mem_rdata, mem_wdata;
  logic [3:0]        mem_wstrb;
  modport master (
    input  ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_single, dc_rd_addr,
           dc_wr_req, dc_wr_single, dc_wr_addr, dc_wr_data, dc_wr_strb,
           mem_gnt, mem_rdata, mem_rvalid, mem_rlast, mem_wready, mem_bvalid,
    output ic_rd_gnt, ic_rd_valid, ic_rd_last, ic_rd_data,
           dc_rd_gnt, dc_rd_valid, dc_rd_last, dc_rd_data,
           dc_wr_gnt, dc_wr_beat_ack, dc_wr_done,
           mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wstrb, mem_wvalid, mem_wlast
  );
  modport slave (
    output ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_single, dc_rd_addr,
           dc_wr_req, dc_wr_single, dc_wr_addr, dc_wr_data, dc_wr_strb,
           mem_gnt, mem_rdata, mem_rvalid, mem_rlast, mem_wready, mem_bvalid,
    input  ic_rd_gnt, ic_rd_valid, ic_rd_last, ic_rd_data,
           dc_rd_gnt, dc_rd_valid, dc_rd_last, dc_rd_data,
           dc_wr_gnt, dc_wr_beat_ack, dc_wr_done,
           mem_req, mem_we, mem_addr, mem_len, mem_wdata, mem_wstrb, mem_wvalid, mem_wlast
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port among icache read, dcache read and dcache write; MEM_ARB_RR_EN selects round-robin over fixed dc_wr > dc_rd > ic_rd
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input logic                clk,
  input logic                rst,
  mem_bus_arbiter_if.master  bus
);
  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam logic [1:0] WR = 2'd0, RD = 2'd1, IC = 2'd2;
  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;
  state_t            state, state_n;
  logic [1:0]        owner_q, win;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        r;
  logic              any, single, grant, wacc, wlast, rd_ic, rd_dc;
  assign r      = {1'b0, bus.ic_rd_req, bus.dc_rd_req, bus.dc_wr_req};
  assign any    = |r;
  assign grant  = state == ADDR && bus.mem_gnt;
  assign wacc   = state == WDATA && bus.mem_wready;
  assign wlast  = 8'(cnt_q) == len_q;
  assign single = win == WR ? bus.dc_wr_single : win == RD && bus.dc_rd_single;
`ifdef MEM_ARB_RR_EN
  logic [1:0] ptr_q, c1, c2;
  assign c1  = ptr_q == IC ? WR : ptr_q + 2'd1;
  assign c2  = c1 == IC ? WR : c1 + 2'd1;
  assign win = r[ptr_q] ? ptr_q : r[c1] ? c1 : c2;
  always_ff @(posedge clk)
    if (rst) ptr_q <= WR;
    else if (grant) ptr_q <= owner_q == IC ? WR : owner_q + 2'd1;
`else
  assign win = r[0] ? WR : r[1] ? RD : IC;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      owner_q <= WR;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        owner_q <= win;
        addr_q  <= win == WR ? bus.dc_wr_addr : win == RD ? bus.dc_rd_addr : bus.ic_rd_addr;
        len_q   <= single ? 8'd0 : 8'(LINE_WORDS - 1);
      end
      cnt_q <= grant ? '0 : wacc ? cnt_q + CW'(1) : cnt_q;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any ? ADDR : IDLE;
      ADDR:    state_n = !bus.mem_gnt ? ADDR : owner_q == WR ? WDATA : RDATA;
      RDATA:   state_n = bus.mem_rvalid && bus.mem_rlast ? IDLE : RDATA;
      WDATA:   state_n = wacc && wlast ? WRESP : WDATA;
      WRESP:   state_n = bus.mem_bvalid ? IDLE : WRESP;
      default: state_n = IDLE;
    endcase
  end
  assign bus.mem_req        = state == ADDR;
  assign bus.mem_we         = state == ADDR && owner_q == WR;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_len        = len_q;
  assign bus.ic_rd_gnt      = grant && owner_q == IC;
  assign bus.dc_rd_gnt      = grant && owner_q == RD;
  assign bus.dc_wr_gnt      = grant && owner_q == WR;
  // read beats pass straight through to whichever requester owns the port
  assign rd_ic              = state == RDATA && bus.mem_rvalid && owner_q == IC;
  assign rd_dc              = state == RDATA && bus.mem_rvalid && owner_q == RD;
  assign bus.ic_rd_valid    = rd_ic;
  assign bus.ic_rd_last     = rd_ic && bus.mem_rlast;
  assign bus.ic_rd_data     = rd_ic ? bus.mem_rdata : '0;
  assign bus.dc_rd_valid    = rd_dc;
  assign bus.dc_rd_last     = rd_dc && bus.mem_rlast;
  assign bus.dc_rd_data     = rd_dc ? bus.mem_rdata : '0;
  assign bus.mem_wvalid     = state == WDATA;
  assign bus.mem_wlast      = state == WDATA && wlast;
  assign bus.mem_wdata      = state == WDATA ? bus.dc_wr_data : '0;
  assign bus.mem_wstrb      = state == WDATA ? bus.dc_wr_strb : '0;
  assign bus.dc_wr_beat_ack = wacc;
  assign bus.dc_wr_done     = state == WRESP && bus.mem_bvalid;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter (LINE_WORDS=4)
module tb_mem_bus_arbiter;
  logic clk, rst;
  mem_bus_arbiter_if #(.ADDR_W(32)) bus();
  mem_bus_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  initial clk = 0;
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0, done_cnt = 0, exp_done = 0, ack_cnt = 0;
  logic [63:0] aq[$], rq[$], wq[$];
  logic [2:0] gv;
  logic [1:0] rv;
  logic outs_or;
  assign outs_or = |{bus.ic_rd_gnt, bus.ic_rd_valid, bus.ic_rd_last, bus.ic_rd_data,
                     bus.dc_rd_gnt, bus.dc_rd_valid, bus.dc_rd_last, bus.dc_rd_data,
                     bus.dc_wr_gnt, bus.dc_wr_beat_ack, bus.dc_wr_done, bus.mem_req, bus.mem_we,
                     bus.mem_addr, bus.mem_len, bus.mem_wdata, bus.mem_wstrb, bus.mem_wvalid, bus.mem_wlast};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_addr(input int o, input logic [31:0] a, input logic [7:0] l);
    aq.push_back(64'({1'(o == 0), a, l, 3'(1 << o)}));
  endtask
  task automatic grant_addr(input int dly, input bit drop);
    logic [2:0] g;
    int n = 0;
    while (!bus.mem_req && n < 50) begin
      tick();
      n++;
    end
    if (!bus.mem_req) check("req_timeout", 64'(bus.mem_req), 1);
    repeat (dly) begin
      tick();
      check("req_hold", 64'(bus.mem_req), 1);
    end
    bus.mem_gnt = 1;
    #1 g = {bus.ic_rd_gnt, bus.dc_rd_gnt, bus.dc_wr_gnt};
    tick();
    bus.mem_gnt = 0;
    if (drop && g[2]) bus.ic_rd_req = 0;
    if (drop && g[1]) bus.dc_rd_req = 0;
    if (drop && g[0]) bus.dc_wr_req = 0;
  endtask
  task automatic rbeats(input logic [1:0] v, input logic [31:0] base, input int n, input int total);
    for (int i = 0; i < n; i++) begin
      bus.mem_rvalid = 1;
      bus.mem_rdata  = base + 32'(i);
      bus.mem_rlast  = i == total - 1;
      rq.push_back(64'({v, base + 32'(i), 1'(i == total - 1)}));
      tick();
    end
    bus.mem_rvalid = 0;
    bus.mem_rlast  = 0;
  endtask
  task automatic wbeats(input int n, input logic [31:0] base, input logic [3:0] strb, input int stall);
    for (int i = 0; i < n; i++) begin
      bus.dc_wr_data = base + 32'(i);
      bus.dc_wr_strb = strb;
      wq.push_back(64'({1'b1, base + 32'(i), strb, 1'(i == n - 1)}));
      repeat (stall < 0 ? i % 2 : stall) tick();
      bus.mem_wready = 1;
      tick();
      bus.mem_wready = 0;
    end
  endtask
  task automatic bresp(input int dly);
    repeat (dly) tick();
    bus.mem_bvalid = 1;
    #1 check("wr_done", 64'(bus.dc_wr_done), 1);
    tick();
    bus.mem_bvalid = 0;
    exp_done++;
  endtask
  always @(negedge clk) if (!rst) begin
    gv = {bus.ic_rd_gnt, bus.dc_rd_gnt, bus.dc_wr_gnt};
    if (bus.mem_req && bus.mem_gnt) begin
      if (aq.size() == 0) check("addr_unexp", 64'(aq.size()), 1);
      else check("addr_phase", 64'({bus.mem_we, bus.mem_addr, bus.mem_len, gv}), aq.pop_front());
    end else if (gv != 0) check("gnt_stray", 64'(gv), 0);
    rv = {bus.ic_rd_valid, bus.dc_rd_valid};
    if (rv != 0) begin
      if (rq.size() == 0) check("rbeat_unexp", 64'(rq.size()), 1);
      else check("rbeat", 64'({rv, bus.ic_rd_valid ? bus.ic_rd_data : bus.dc_rd_data,
                               bus.ic_rd_last | bus.dc_rd_last}), rq.pop_front());
    end
    if (bus.mem_wvalid && bus.mem_wready) begin
      if (wq.size() == 0) check("wbeat_unexp", 64'(wq.size()), 1);
      else check("wbeat", 64'({bus.dc_wr_beat_ack, bus.mem_wdata, bus.mem_wstrb, bus.mem_wlast}), wq.pop_front());
    end else if (bus.dc_wr_beat_ack) check("ack_stray", 64'(bus.dc_wr_beat_ack), 0);
    if (bus.dc_wr_beat_ack) ack_cnt++;
    if (bus.dc_wr_done) done_cnt++;
  end
  initial begin
    int acks0;
    int ord[4];
`ifdef MEM_ARB_RR_EN
    ord = '{0, 1, 2, 0};
`else
    ord = '{0, 0, 0, 0};
`endif
    rst = 1;
    {bus.ic_rd_req, bus.ic_rd_addr, bus.dc_rd_req, bus.dc_rd_single, bus.dc_rd_addr} = '0;
    {bus.dc_wr_req, bus.dc_wr_single, bus.dc_wr_addr, bus.dc_wr_data, bus.dc_wr_strb} = '0;
    {bus.mem_gnt, bus.mem_rdata, bus.mem_rvalid, bus.mem_rlast, bus.mem_wready, bus.mem_bvalid} = '0;
    repeat (2) tick();
    check("reset_outs", 64'(outs_or), 0);
    rst = 0;
    tick();
    bus.ic_rd_req  = 1;
    bus.ic_rd_addr = 32'h1C00_0040;
    exp_addr(2, 32'h1C00_0040, 8'd3);
    check("req_before_arb", 64'(bus.mem_req), 0);
    tick();
    check("req_latency", 64'(bus.mem_req), 1);
    bus.mem_rvalid = 1;
    bus.mem_rlast  = 1;
    tick();
    bus.mem_rvalid = 0;
    bus.mem_rlast  = 0;
    grant_addr(1, 1);
    rbeats(2'b10, 32'hA0, 4, 4);
    tick();
    bus.ic_rd_req    = 1;
    bus.ic_rd_addr   = 32'h1C00_0100;
    bus.dc_rd_req    = 1;
    bus.dc_rd_single = 0;
    bus.dc_rd_addr   = 32'h2000_0200;
    exp_addr(1, 32'h2000_0200, 8'd3);
    exp_addr(2, 32'h1C00_0100, 8'd3);
    grant_addr(1, 1);
    rbeats(2'b01, 32'hB0, 4, 4);
    check("turnaround_idle", 64'(bus.mem_req), 0);
    tick();
    check("ic_after_dc", 64'(bus.mem_req), 1);
    grant_addr(0, 1);
    rbeats(2'b10, 32'hC0, 4, 4);
    bus.dc_wr_req    = 1;
    bus.dc_wr_single = 1;
    bus.dc_wr_addr   = 32'h4000_0008;
    bus.dc_wr_data   = 32'hDEAD_BEEF;
    bus.dc_wr_strb   = 4'h3;
    exp_addr(0, 32'h4000_0008, 8'd0);
    grant_addr(0, 1);
    bus.mem_bvalid = 1;
    #1 check("bvalid_early", 64'(bus.dc_wr_done), 0);
    tick();
    bus.mem_bvalid = 0;
    wbeats(1, 32'hDEAD_BEEF, 4'h3, 2);
    bresp(2);
    tick();
    bus.dc_wr_req    = 1;
    bus.dc_wr_single = 0;
    bus.dc_wr_addr   = 32'h4000_0100;
    exp_addr(0, 32'h4000_0100, 8'd3);
    grant_addr(2, 1);
    acks0 = ack_cnt;
    wbeats(4, 32'h5000_0000, 4'hF, -1);
    check("line_acks", 64'(ack_cnt - acks0), 4);
    bresp(1);
    bus.ic_rd_req  = 1;
    bus.ic_rd_addr = 32'h1C00_0080;
    exp_addr(2, 32'h1C00_0080, 8'd3);
    grant_addr(0, 1);
    rbeats(2'b10, 32'hD0, 2, 4);
    rst = 1;
    tick();
    check("rst_mid_outs", 64'(outs_or), 0);
    rst = 0;
    bus.ic_rd_req  = 1;
    bus.ic_rd_addr = 32'h1C00_00C0;
    exp_addr(2, 32'h1C00_00C0, 8'd3);
    grant_addr(0, 1);
    rbeats(2'b10, 32'h90, 4, 4);
    bus.dc_wr_req    = 1;
    bus.dc_wr_single = 1;
    bus.dc_wr_addr   = 32'h3000_0000;
    bus.dc_rd_req    = 1;
    bus.dc_rd_single = 1;
    bus.dc_rd_addr   = 32'h3000_0010;
    bus.ic_rd_req    = 1;
    bus.ic_rd_addr   = 32'h3000_0020;
    for (int k = 0; k < 4; k++) begin
      exp_addr(ord[k], ord[k] == 0 ? 32'h3000_0000 : ord[k] == 1 ? 32'h3000_0010 : 32'h3000_0020,
               ord[k] == 2 ? 8'd3 : 8'd0);
      grant_addr(0, 0);
      if (ord[k] == 0) begin
        wbeats(1, 32'h1111_0000 + 32'(k), 4'hF, 0);
        bresp(0);
      end else if (ord[k] == 1) rbeats(2'b01, 32'hE0, 1, 1);
      else rbeats(2'b10, 32'hF0, 4, 4);
    end
    {bus.dc_wr_req, bus.dc_rd_req, bus.ic_rd_req} = '0;
    repeat (2) tick();
    check("idle_end", 64'(bus.mem_req), 0);
    check("addr_q_empty", 64'(aq.size()), 0);
    check("rbeat_q_empty", 64'(rq.size()), 0);
    check("wbeat_q_empty", 64'(wq.size()), 0);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
